// File: rtl/rect_motion_pkg.sv
// Shared types and defaults for the bouncing-rectangle motion scheduler.
package rect_motion_pkg;

    localparam int POS_W_DEF   = 12;
    localparam int SPD_W_DEF   = 10;
    localparam int FLOOR_Y_DEF = 536;
    localparam int ACC_DIV_DEF = 3;
    localparam int ACC_W       = 5;

    typedef enum logic {
        PH_FALL  = 1'b0,
        PH_RAISE = 1'b1
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rect_motion_step.sv
// Combinational gravity/bounce step for one object; shared by all objects.
module rect_motion_step
    import rect_motion_pkg::*;
#(
    parameter int POS_W   = POS_W_DEF,
    parameter int SPD_W   = SPD_W_DEF,
    parameter int FLOOR_Y = FLOOR_Y_DEF,
    parameter int ACC_DIV = ACC_DIV_DEF
) (
    input  logic [POS_W-1:0] y,
    input  logic [SPD_W-1:0] spd,
    input  logic [ACC_W-1:0] acc,
    input  phase_e           phase,
    output logic [POS_W-1:0] y_nxt,
    output logic [SPD_W-1:0] spd_nxt,
    output logic [ACC_W-1:0] acc_nxt,
    output phase_e           phase_nxt
);

    localparam logic [SPD_W-1:0] SPD_MAX = '1;

    logic [POS_W:0]   reach;
    logic [POS_W:0]   y_sum;
    logic [ACC_W-1:0] acc_inc;
    logic             acc_wrap;

    always_comb begin
        reach     = {1'b0, y} + (POS_W+1)'(spd);
        acc_inc   = acc + 1'b1;
        acc_wrap  = (acc_inc == ACC_W'(ACC_DIV));
        y_sum     = '0;
        y_nxt     = y;
        spd_nxt   = spd;
        acc_nxt   = acc;
        phase_nxt = phase;
        if (phase == PH_FALL) begin
            if (reach >= (POS_W+1)'(FLOOR_Y)) begin
                phase_nxt = PH_RAISE;
                spd_nxt   = spd >> 1;
            end else begin
                acc_nxt = acc_wrap ? '0 : acc_inc;
                if (acc_wrap && spd != SPD_MAX) spd_nxt = spd + 1'b1;
                y_sum = {1'b0, y} + (POS_W+1)'(spd_nxt);
                y_nxt = y_sum[POS_W] ? '1 : y_sum[POS_W-1:0];
            end
        end else begin
            if (spd <= SPD_W'(1)) begin
                phase_nxt = PH_FALL;
            end else begin
                acc_nxt = acc_wrap ? '0 : acc_inc;
                if (acc_wrap) spd_nxt = spd - 1'b1;
                // Rising objects stop at the top edge instead of wrapping.
                y_nxt = ({1'b0, y} >= (POS_W+1)'(spd_nxt)) ? y - POS_W'(spd_nxt) : '0;
            end
        end
    end

endmodule

// File: rtl/rect_motion_sched.sv
// Frame scheduler: walks all objects through one shared step unit per vsync rise.
// Optional overrun counter enabled by defining RECT_SCHED_OVERRUN_EN.
module rect_motion_sched
    import rect_motion_pkg::*;
#(
    parameter int N_OBJ   = 4,
    parameter int POS_W   = POS_W_DEF,
    parameter int SPD_W   = SPD_W_DEF,
    parameter int FLOOR_Y = FLOOR_Y_DEF,
    parameter int ACC_DIV = ACC_DIV_DEF
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic                   vsync,
    input  logic [N_OBJ-1:0]       obj_en,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [3:0]             load_idx,
    input  logic [POS_W-1:0]       load_xpos,
    input  logic [POS_W-1:0]       load_ypos,
    output logic [N_OBJ*POS_W-1:0] xpos_out,
    output logic [N_OBJ*POS_W-1:0] ypos_out,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             overrun_cnt
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic [N_OBJ-1:0][POS_W-1:0] xpos, ypos;
    logic [N_OBJ-1:0][SPD_W-1:0] spd;
    logic [N_OBJ-1:0][ACC_W-1:0] acc;
    logic [N_OBJ-1:0]            ph;

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic             vsync_q;
    logic             vs_rise;
    logic             load_fire;

    logic [POS_W-1:0] y_nxt;
    logic [SPD_W-1:0] spd_nxt;
    logic [ACC_W-1:0] acc_nxt;
    phase_e           phase_nxt;

    assign vs_rise    = vsync & ~vsync_q;
    assign load_ready = (state == ST_IDLE);
    assign load_fire  = load_valid & load_ready & (32'(load_idx) < N_OBJ);
    assign xpos_out   = xpos;
    assign ypos_out   = ypos;

    rect_motion_step #(
        .POS_W(POS_W), .SPD_W(SPD_W), .FLOOR_Y(FLOOR_Y), .ACC_DIV(ACC_DIV)
    ) u_step (
        .y(ypos[idx]), .spd(spd[idx]), .acc(acc[idx]), .phase(phase_e'(ph[idx])),
        .y_nxt(y_nxt), .spd_nxt(spd_nxt), .acc_nxt(acc_nxt), .phase_nxt(phase_nxt)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            xpos       <= '0;
            ypos       <= '0;
            spd        <= '0;
            acc        <= '0;
            ph         <= '0;
            state      <= ST_IDLE;
            idx        <= '0;
            vsync_q    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A load in the same cycle as vs_rise lands before the first step reads it.
                    if (load_fire) begin
                        xpos[load_idx[IDX_W-1:0]] <= load_xpos;
                        ypos[load_idx[IDX_W-1:0]] <= load_ypos;
                        spd[load_idx[IDX_W-1:0]]  <= '0;
                        acc[load_idx[IDX_W-1:0]]  <= '0;
                        ph[load_idx[IDX_W-1:0]]   <= PH_FALL;
                    end
                    if (vs_rise) begin
                        state <= ST_STEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (obj_en[idx]) begin
                        ypos[idx] <= y_nxt;
                        spd[idx]  <= spd_nxt;
                        acc[idx]  <= acc_nxt;
                        ph[idx]   <= phase_nxt;
                    end
                    if (idx == IDX_W'(N_OBJ - 1)) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RECT_SCHED_OVERRUN_EN
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
        end else if (vs_rise && busy && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_rect_motion_sched.sv
// Self-checking bench for rect_motion_sched with an arithmetic reference model.
module tb_rect_motion_sched;

    localparam int N       = 2;
    localparam int POS_W   = 12;
    localparam int SPD_W   = 10;
    localparam int FLOOR_Y = 104;
    localparam int ACC_DIV = 3;
    localparam int POS_MAX = (1 << POS_W) - 1;
    localparam int SPD_MAX = (1 << SPD_W) - 1;

    logic               pclk = 1'b0;
    logic               rst_n;
    logic               vsync;
    logic [N-1:0]       obj_en;
    logic               load_valid;
    logic               load_ready;
    logic [3:0]         load_idx;
    logic [POS_W-1:0]   load_xpos;
    logic [POS_W-1:0]   load_ypos;
    logic [N*POS_W-1:0] xpos_out;
    logic [N*POS_W-1:0] ypos_out;
    logic               busy;
    logic               frame_done;
    logic [7:0]         overrun_cnt;

    int checks = 0;
    int errors = 0;

    // Reference object state, plain integers
    int mx[N], my[N], ms[N], ma[N], mp[N];
    int exp_ovr = 0;

    always #5 pclk = ~pclk;

    rect_motion_sched #(
        .N_OBJ(N), .POS_W(POS_W), .SPD_W(SPD_W), .FLOOR_Y(FLOOR_Y), .ACC_DIV(ACC_DIV)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .obj_en(obj_en),
        .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
        .load_xpos(load_xpos), .load_ypos(load_ypos),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .busy(busy),
        .frame_done(frame_done), .overrun_cnt(overrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; ms[i] = 0; ma[i] = 0; mp[i] = 0;
        end
        exp_ovr = 0;
    endfunction

    function automatic void model_load(input int li, input int lx, input int ly);
        if (li < N) begin
            mx[li] = lx; my[li] = ly; ms[li] = 0; ma[li] = 0; mp[li] = 0;
        end
    endfunction

    function automatic void model_frame(input logic [N-1:0] en);
        for (int i = 0; i < N; i++) begin
            if (!en[i]) continue;
            if (mp[i] == 0) begin
                if (my[i] + ms[i] >= FLOOR_Y) begin
                    mp[i] = 1;
                    ms[i] = ms[i] / 2;
                end else begin
                    ma[i]++;
                    if (ma[i] == ACC_DIV) begin
                        ma[i] = 0;
                        if (ms[i] < SPD_MAX) ms[i]++;
                    end
                    my[i] = (my[i] + ms[i] > POS_MAX) ? POS_MAX : my[i] + ms[i];
                end
            end else begin
                if (ms[i] <= 1) begin
                    mp[i] = 0;
                end else begin
                    ma[i]++;
                    if (ma[i] == ACC_DIV) begin
                        ma[i] = 0;
                        ms[i]--;
                    end
                    my[i] = (my[i] < ms[i]) ? 0 : my[i] - ms[i];
                end
            end
        end
    endfunction

    task automatic check_pos(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_x%0d", tag, i), 32'(xpos_out[i*POS_W +: POS_W]), 32'(mx[i]));
            check($sformatf("%s_y%0d", tag, i), 32'(ypos_out[i*POS_W +: POS_W]), 32'(my[i]));
        end
    endtask

    task automatic do_load(input int li, input int lx, input int ly);
        check("load_ready_idle", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_idx   = 4'(li);
        load_xpos  = POS_W'(lx);
        load_ypos  = POS_W'(ly);
        tick();
        load_valid = 1'b0;
        model_load(li, lx, ly);
    endtask

    // One vsync rise with optional coincident load; checks latency and final positions.
    task automatic run_frame(input logic [N-1:0] en, input bit ld, input int li,
                             input int lx, input int ly);
        int n;
        obj_en = en;
        vsync  = 1'b1;
        if (ld) begin
            load_valid = 1'b1;
            load_idx   = 4'(li);
            load_xpos  = POS_W'(lx);
            load_ypos  = POS_W'(ly);
        end
        tick();
        vsync      = 1'b0;
        load_valid = 1'b0;
        if (ld) model_load(li, lx, ly);
        check("busy_t1", 32'(busy), 32'd1);
        check("ready_t1", 32'(load_ready), 32'd0);
        check("fd_t1", 32'(frame_done), 32'd0);
        n = 0;
        while (!frame_done && n < 10) begin
            tick();
            n++;
        end
        check("fd_latency", 32'(n), 32'(N));
        check("busy_at_fd", 32'(busy), 32'd1);
        tick();
        check("fd_pulse_end", 32'(frame_done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        model_frame(en);
        check_pos("frame");
    endtask

    initial begin
        int exp_y[9];
        int fd_cnt;
        rst_n      = 1'b0;
        vsync      = 1'b0;
        obj_en     = '1;
        load_valid = 1'b0;
        load_idx   = '0;
        load_xpos  = '0;
        load_ypos  = '0;
        model_reset();
        tick();
        tick();
        check("rst_x", 32'(xpos_out), 32'd0);
        check("rst_y", 32'(ypos_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed trajectory for obj0 from y=100
        exp_y = '{100, 100, 101, 102, 103, 103, 103, 104, 104};
        do_load(0, 33, 100);
        do_load(1, 500, 20);
        check_pos("after_load");
        for (int f = 0; f < 9; f++) begin
            run_frame(2'b11, 1'b0, 0, 0, 0);
            check($sformatf("traj_f%0d", f + 1), 32'(ypos_out[0 +: POS_W]), 32'(exp_y[f]));
        end

        // obj1 frozen, obj0 re-run from y=100
        do_load(0, 7, 100);
        do_load(1, 900, 60);
        for (int f = 0; f < 5; f++) begin
            run_frame(2'b01, 1'b0, 0, 0, 0);
            check($sformatf("en01_f%0d", f + 1), 32'(ypos_out[0 +: POS_W]), 32'(exp_y[f]));
            check("frozen_y1", 32'(ypos_out[POS_W +: POS_W]), 32'd60);
        end

        // Second rise while busy is ignored
        obj_en = 2'b11;
        vsync  = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        fd_cnt = int'(frame_done);
        for (int c = 0; c < 8; c++) begin
            tick();
            fd_cnt += int'(frame_done);
        end
        model_frame(2'b11);
`ifdef RECT_SCHED_OVERRUN_EN
        exp_ovr = 1;
`endif
        check("overrun_fd_count", 32'(fd_cnt), 32'd1);
        check("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));
        check("overrun_idle", 32'(busy), 32'd0);
        check_pos("overrun");

        // Coincident load and vs_rise: step sees the loaded value
        run_frame(2'b11, 1'b1, 1, 321, 103);

        // Randomized loads (including out-of-range indices) and frames
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load($urandom_range(0, 3), $urandom_range(0, POS_MAX),
                        ($urandom_range(0, 7) == 0) ? $urandom_range(0, POS_MAX)
                                                    : $urandom_range(0, 130));
                check_pos("rnd_load");
            end else begin
                run_frame(N'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 3), $urandom_range(0, POS_MAX),
                          $urandom_range(0, 120));
            end
        end
        check("rnd_ovr", 32'(overrun_cnt), 32'(exp_ovr));

        // Reset in the middle of STEP
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_x", 32'(xpos_out), 32'd0);
        check("mid_rst_y", 32'(ypos_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        check("mid_rst_ovr", 32'(overrun_cnt), 32'd0);
        fd_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            fd_cnt += int'(frame_done);
        end
        check("mid_rst_no_fd", 32'(fd_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();
        tick();
        do_load(0, 11, 100);
        do_load(1, 22, 102);
        run_frame(2'b11, 1'b0, 0, 0, 0);
        run_frame(2'b11, 1'b0, 0, 0, 0);
        run_frame(2'b11, 1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
